// File: rtl/move_sched.sv
// -----------------------------------------------------------------------------
// move_sched
//   Per-frame scheduler that time-shares a single `move` collision/step
//   datapath between N_OBJ object slots. It owns the pos/rem/spd state table.
//   On each frame tick it sweeps the active slots in index order. For each
//   active slot it presents the slot state to `move`, waits MOVE_LAT cycles,
//   and then writes the result back into the slot. Game logic loads slots
//   through the write port between sweeps. It can inspect slots at any time
//   through the combinational read port.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   frame_tick_i            1-cycle pulse that starts a sweep
//   busy_o                  a sweep is in progress (FSM not idle)
//   done_o                  1-cycle pulse when a sweep finishes
//   overrun_o               1-cycle pulse, one cycle after a tick that was
//                           dropped because a sweep was already running
//   wr_valid_i/wr_ready_o   slot write handshake (ready only while idle)
//   wr_idx_i, wr_active_i,
//   wr_pos_i, wr_rem_i,
//   wr_spd_i                slot write payload
//   rd_idx_i                read index
//   rd_active_o, rd_pos_o,
//   rd_spd_o                combinational view of slot[rd_idx_i]
//   mv_pos_o/rem_o/spd_o    registered operands driven to `move`
//   mv_pos_i/rem_i/spd_i    results returned by `move`
// -----------------------------------------------------------------------------
module move_sched #(
    parameter int N_OBJ    = 8,
    parameter int MOVE_LAT = 1,
    localparam int IW      = $clog2(N_OBJ)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          frame_tick_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          overrun_o,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [IW-1:0] wr_idx_i,
    input  logic          wr_active_i,
    input  logic [31:0]   wr_pos_i,
    input  logic [63:0]   wr_rem_i,
    input  logic [63:0]   wr_spd_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic          rd_active_o,
    output logic [31:0]   rd_pos_o,
    output logic [63:0]   rd_spd_o,
    output logic [31:0]   mv_pos_o,
    output logic [63:0]   mv_rem_o,
    output logic [63:0]   mv_spd_o,
    input  logic [31:0]   mv_pos_i,
    input  logic [63:0]   mv_rem_i,
    input  logic [63:0]   mv_spd_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_OBJ - 1);
    localparam logic [IW:0]   N_OBJ_W  = (IW + 1)'(N_OBJ);
    localparam int            CW       = (MOVE_LAT > 1) ? $clog2(MOVE_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'((MOVE_LAT > 0) ? (MOVE_LAT - 1) : 0);

    // ---------------------------------------------------------------- state
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mv_pos_q, mv_pos_d;
    logic [63:0]   mv_rem_q, mv_rem_d;
    logic [63:0]   mv_spd_q, mv_spd_d;
    logic          ready_q, ready_d;
    logic          overrun_q, overrun_d;

    // Slot table. It is kept in flops because it needs an asynchronous clear
    // and a combinational read port.
    logic          act_q [N_OBJ];
    logic          act_d [N_OBJ];
    logic [31:0]   pos_q [N_OBJ];
    logic [31:0]   pos_d [N_OBJ];
    logic [63:0]   rem_q [N_OBJ];
    logic [63:0]   rem_d [N_OBJ];
    logic [63:0]   spd_q [N_OBJ];
    logic [63:0]   spd_d [N_OBJ];

    logic wr_fire;
    logic commit_en;
    logic rd_in_range;

    // ready_q is only ever high in IDLE. A write therefore can never collide
    // with a COMMIT to the same slot.
    assign wr_fire   = wr_valid_i & ready_q;
    assign commit_en = (state_q == S_COMMIT);

    // ------------------------------------------------------------ FSM logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mv_pos_d  = mv_pos_q;
        mv_rem_d  = mv_rem_q;
        mv_spd_d  = mv_spd_q;
        overrun_d = frame_tick_i && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (frame_tick_i) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (act_q[idx_q]) begin
                    state_d = S_ISSUE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_ISSUE: begin
                mv_pos_d = pos_q[idx_q];
                mv_rem_d = rem_q[idx_q];
                mv_spd_d = spd_q[idx_q];
                cnt_d    = '0;
                state_d  = (MOVE_LAT > 0) ? S_WAIT : S_COMMIT;
            end
            S_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_COMMIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready is registered from the next state. It drops on the same edge
        // that leaves IDLE, and it rises on the edge that returns to IDLE.
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            mv_pos_q  <= '0;
            mv_rem_q  <= '0;
            mv_spd_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mv_pos_q  <= mv_pos_d;
            mv_rem_q  <= mv_rem_d;
            mv_spd_q  <= mv_spd_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    // ----------------------------------------------------------- slot table
    genvar gi;
    generate
        for (gi = 0; gi < N_OBJ; gi++) begin : g_slot
            logic wr_hit;
            logic cm_hit;

            assign wr_hit = wr_fire && (wr_idx_i == IW'(gi));
            assign cm_hit = commit_en && (idx_q == IW'(gi));

            // The sweep never touches the active flag. Only the write port
            // changes the active flag.
            always_comb begin
                act_d[gi] = act_q[gi];
                pos_d[gi] = pos_q[gi];
                rem_d[gi] = rem_q[gi];
                spd_d[gi] = spd_q[gi];
                if (wr_hit) begin
                    act_d[gi] = wr_active_i;
                    pos_d[gi] = wr_pos_i;
                    rem_d[gi] = wr_rem_i;
                    spd_d[gi] = wr_spd_i;
                end else if (cm_hit) begin
                    pos_d[gi] = mv_pos_i;
                    rem_d[gi] = mv_rem_i;
                    spd_d[gi] = mv_spd_i;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    act_q[gi] <= 1'b0;
                    pos_q[gi] <= '0;
                    rem_q[gi] <= '0;
                    spd_q[gi] <= '0;
                end else begin
                    act_q[gi] <= act_d[gi];
                    pos_q[gi] <= pos_d[gi];
                    rem_q[gi] <= rem_d[gi];
                    spd_q[gi] <= spd_d[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------- outputs
    // When N_OBJ is not a power of two, indices past the last slot read as an
    // empty slot.
    assign rd_in_range = ({1'b0, rd_idx_i} < N_OBJ_W);
    assign rd_active_o = rd_in_range ? act_q[rd_idx_i] : 1'b0;
    assign rd_pos_o    = rd_in_range ? pos_q[rd_idx_i] : '0;
    assign rd_spd_o    = rd_in_range ? spd_q[rd_idx_i] : '0;

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign overrun_o  = overrun_q;
    assign wr_ready_o = ready_q;
    assign mv_pos_o   = mv_pos_q;
    assign mv_rem_o   = mv_rem_q;
    assign mv_spd_o   = mv_spd_q;

endmodule

// File: tb/tb_move_sched.sv
module tb_move_sched;

    localparam int N_OBJ    = 8;
    localparam int MOVE_LAT = 1;
    localparam int IW       = 3;
    localparam int TMO      = 400;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          frame_tick_i;
    logic          busy_o, done_o, overrun_o;
    logic          wr_valid_i, wr_ready_o;
    logic [IW-1:0] wr_idx_i;
    logic          wr_active_i;
    logic [31:0]   wr_pos_i;
    logic [63:0]   wr_rem_i, wr_spd_i;
    logic [IW-1:0] rd_idx_i;
    logic          rd_active_o;
    logic [31:0]   rd_pos_o;
    logic [63:0]   rd_spd_o;
    logic [31:0]   mv_pos_o, mv_pos_i;
    logic [63:0]   mv_rem_o, mv_rem_i, mv_spd_o, mv_spd_i;

    always #5 clk_i = ~clk_i;

    // Move stub: pos advances by {y+2, x+1}. rem and spd pass through.
    assign mv_pos_i = {mv_pos_o[31:16] + 16'd2, mv_pos_o[15:0] + 16'd1};
    assign mv_rem_i = mv_rem_o;
    assign mv_spd_i = mv_spd_o;

    move_sched #(.N_OBJ(N_OBJ), .MOVE_LAT(MOVE_LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .frame_tick_i(frame_tick_i),
        .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_idx_i(wr_idx_i),
        .wr_active_i(wr_active_i), .wr_pos_i(wr_pos_i), .wr_rem_i(wr_rem_i),
        .wr_spd_i(wr_spd_i), .rd_idx_i(rd_idx_i), .rd_active_o(rd_active_o),
        .rd_pos_o(rd_pos_o), .rd_spd_o(rd_spd_o),
        .mv_pos_o(mv_pos_o), .mv_rem_o(mv_rem_o), .mv_spd_o(mv_spd_o),
        .mv_pos_i(mv_pos_i), .mv_rem_i(mv_rem_i), .mv_spd_i(mv_spd_i)
    );

    int checks;
    int failures;

    // Event counters. They are written only by this monitor. The stimulus
    // takes snapshots of them and compares the differences.
    int done_cnt = 0;
    int ov_cnt   = 0;
    int busy_cnt = 0;
    int mv_chg   = 0;
    logic [159:0] mv_prev = '0;

    always @(negedge clk_i) begin
        if (done_o)    done_cnt++;
        if (overrun_o) ov_cnt++;
        if (busy_o)    busy_cnt++;
        if ({mv_pos_o, mv_rem_o, mv_spd_o} !== mv_prev) mv_chg++;
        mv_prev = {mv_pos_o, mv_rem_o, mv_spd_o};
    end

    // Reference model of the slot table.
    logic        m_act [N_OBJ];
    logic [31:0] m_pos [N_OBJ];
    logic [63:0] m_rem [N_OBJ];
    logic [63:0] m_spd [N_OBJ];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N_OBJ; i++) begin
            m_act[i] = 1'b0; m_pos[i] = '0; m_rem[i] = '0; m_spd[i] = '0;
        end
    endfunction

    function automatic void model_sweep();
        for (int i = 0; i < N_OBJ; i++)
            if (m_act[i]) m_pos[i] = {m_pos[i][31:16] + 16'd2, m_pos[i][15:0] + 16'd1};
    endfunction

    // Timing: each slot costs 1 SCAN cycle. Each active slot adds
    // ISSUE + MOVE_LAT + COMMIT. DONE adds one more cycle.
    function automatic int exp_cycles();
        int n = 0;
        for (int i = 0; i < N_OBJ; i++) if (m_act[i]) n++;
        return N_OBJ + 1 + n * (MOVE_LAT + 2);
    endfunction

    task automatic idle_inputs();
        frame_tick_i = 0; wr_valid_i = 0; wr_idx_i = '0; wr_active_i = 0;
        wr_pos_i = '0; wr_rem_i = '0; wr_spd_i = '0; rd_idx_i = '0;
    endtask

    task automatic release_reset();
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_eq("ready_after_rst", 64'(wr_ready_o), 64'd1);
        model_clear();
    endtask

    task automatic write_slot(input int idx, input logic act, input logic [31:0] p,
                              input logic [63:0] r, input logic [63:0] s);
        int n;
        n = 0;
        wr_valid_i = 1; wr_idx_i = IW'(idx); wr_active_i = act;
        wr_pos_i = p; wr_rem_i = r; wr_spd_i = s;
        while (wr_ready_o !== 1'b1 && n < TMO) begin @(posedge clk_i); #1; n++; end
        if (n >= TMO) check_eq("wr_ready_timeout", 64'(wr_ready_o), 64'd1);
        @(posedge clk_i); #1;
        wr_valid_i = 0;
        m_act[idx] = act; m_pos[idx] = p; m_rem[idx] = r; m_spd[idx] = s;
        $display("write slot=%0d act=%0b pos=%h", idx, act, p);
    endtask

    // Called one cycle after the tick edge. Returns the number of that cycle
    // (counted from 1) in which done_o is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (done_o !== 1'b1 && n < TMO) begin @(posedge clk_i); #1; n++; end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N_OBJ; i++) begin
            @(negedge clk_i); rd_idx_i = IW'(i); #1;
            check_eq({tag, "_act"}, 64'(rd_active_o), 64'(m_act[i]));
            check_eq({tag, "_pos"}, 64'(rd_pos_o), 64'(m_pos[i]));
            check_eq({tag, "_spd"}, rd_spd_o, m_spd[i]);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic run_sweep(input string tag);
        int n, exp_n, d0, b0, last;
        logic [31:0] lp;
        logic [63:0] lr, ls;
        exp_n = exp_cycles();
        last = -1; lp = '0; lr = '0; ls = '0;
        for (int i = 0; i < N_OBJ; i++) if (m_act[i]) last = i;
        if (last >= 0) begin lp = m_pos[last]; lr = m_rem[last]; ls = m_spd[last]; end
        d0 = done_cnt; b0 = busy_cnt;
        frame_tick_i = 1; @(posedge clk_i); #1; frame_tick_i = 0;
        wait_done(n);
        check_eq({tag, "_done_at"}, 64'(n), 64'(exp_n));
        @(posedge clk_i); #1;
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt - b0), 64'(exp_n));
        check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check_eq({tag, "_idle"}, 64'(busy_o), 64'd0);
        if (last >= 0) begin
            check_eq({tag, "_mv_pos"}, 64'(mv_pos_o), 64'(lp));
            check_eq({tag, "_mv_rem"}, mv_rem_o, lr);
            check_eq({tag, "_mv_spd"}, mv_spd_o, ls);
        end
        model_sweep();
        $display("sweep %s cycles=%0d expected=%0d", tag, n, exp_n);
    endtask

    initial begin
        int n, d0, o0, b0, m0, rdy_busy;
        logic [31:0] p;
        checks = 0; failures = 0;
        rst_ni = 1'b0;
        idle_inputs();
        model_clear();

        // Values held while reset is asserted
        repeat (2) @(posedge clk_i); #1;
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_overrun", 64'(overrun_o), 64'd0);
        check_eq("rst_mv_pos", 64'(mv_pos_o), 64'd0);
        check_eq("rst_mv_rem", mv_rem_o, 64'd0);
        check_eq("rst_mv_spd", mv_spd_o, 64'd0);
        release_reset();
        check_all("rst_tbl");

        // A single active slot
        write_slot(3, 1'b1, 32'h0010_0028, 64'(32'($urandom)), 64'h0000_0000_0001_8000);
        run_sweep("single");
        check_all("single_tbl");
        rd_idx_i = 3; #1;
        check_eq("single_pos", 64'(rd_pos_o), 64'h0012_0029);

        // All slots active, two sweeps
        for (int i = 0; i < N_OBJ; i++)
            write_slot(i, 1'b1, $urandom, {$urandom, $urandom}, {$urandom, $urandom});
        run_sweep("all1");
        run_sweep("all2");
        check_all("all_tbl");

        // Random active patterns
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_OBJ; i++)
                write_slot(i, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, {$urandom, $urandom});
            run_sweep("rand");
            check_all("rand_tbl");
        end

        // A tick during a sweep is dropped and flagged
        for (int i = 0; i < N_OBJ; i++)
            write_slot(i, 1'b1, $urandom, {$urandom, $urandom}, {$urandom, $urandom});
        d0 = done_cnt; o0 = ov_cnt;
        frame_tick_i = 1; @(posedge clk_i); #1; frame_tick_i = 0;
        repeat (4) begin @(posedge clk_i); #1; end
        frame_tick_i = 1; @(posedge clk_i); #1; frame_tick_i = 0;
        wait_done(n);
        repeat (4) begin @(posedge clk_i); #1; end
        check_eq("ovr_pulses", 64'(ov_cnt - o0), 64'd1);
        check_eq("ovr_done_pulses", 64'(done_cnt - d0), 64'd1);
        check_eq("ovr_idle", 64'(busy_o), 64'd0);
        model_sweep();
        check_all("ovr_tbl");
        $display("overrun sweep done_at=%0d", n);

        // A write held during busy stalls until IDLE and lands afterwards
        frame_tick_i = 1; @(posedge clk_i); #1; frame_tick_i = 0;
        p = $urandom;
        wr_valid_i = 1; wr_idx_i = 5; wr_active_i = 1; wr_pos_i = p;
        wr_rem_i = 64'h1234_5678_9abc_def0; wr_spd_i = 64'h0fed_cba9_8765_4321;
        rdy_busy = 0; n = 1;
        while (done_o !== 1'b1 && n < TMO) begin
            if (wr_ready_o) rdy_busy++;
            @(posedge clk_i); #1; n++;
        end
        check_eq("wb_done_at", 64'(n), 64'(exp_cycles()));
        check_eq("wb_ready_busy", 64'(rdy_busy), 64'd0);
        check_eq("wb_ready_in_done", 64'(wr_ready_o), 64'd0);
        model_sweep();
        @(posedge clk_i); #1;
        check_eq("wb_ready_idle", 64'(wr_ready_o), 64'd1);
        rd_idx_i = 5; #1;
        check_eq("wb_pre_land", 64'(rd_pos_o), 64'(m_pos[5]));
        @(posedge clk_i); #1;
        wr_valid_i = 0;
        m_act[5] = 1; m_pos[5] = p; m_rem[5] = wr_rem_i; m_spd[5] = wr_spd_i;
        check_all("wb_tbl");
        $display("busy write slot=5 pos=%h", p);

        // A write and a tick on the same edge: the sweep sees the new value
        p = $urandom;
        wr_valid_i = 1; wr_idx_i = 0; wr_active_i = 1; wr_pos_i = p;
        wr_rem_i = {$urandom, $urandom}; wr_spd_i = {$urandom, $urandom};
        frame_tick_i = 1;
        @(posedge clk_i); #1;
        frame_tick_i = 0; wr_valid_i = 0;
        m_act[0] = 1; m_pos[0] = p; m_rem[0] = wr_rem_i; m_spd[0] = wr_spd_i;
        wait_done(n);
        check_eq("same_edge_done_at", 64'(n), 64'(exp_cycles()));
        model_sweep();
        @(posedge clk_i); #1;
        check_all("same_edge_tbl");
        $display("same-edge write+tick slot=0 pos=%h", p);

        // Reset asserted in WAIT aborts the sweep and clears the table
        rst_ni = 0; #1; release_reset();
        write_slot(0, 1'b1, 32'h0008_0008, 64'd0, 64'd0);
        d0 = done_cnt;
        frame_tick_i = 1; @(posedge clk_i); #1; frame_tick_i = 0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 0; #1;
        check_eq("rstw_busy", 64'(busy_o), 64'd0);
        rd_idx_i = 0; #1;
        check_eq("rstw_act", 64'(rd_active_o), 64'd0);
        check_eq("rstw_pos", 64'(rd_pos_o), 64'd0);
        repeat (2) @(posedge clk_i);
        release_reset();
        repeat (5) begin @(posedge clk_i); #1; end
        check_eq("rstw_no_done", 64'(done_cnt - d0), 64'd0);
        $display("reset mid-wait done");

        // All slots inactive, one of them holding data
        m0 = mv_chg; b0 = busy_cnt;
        write_slot(2, 1'b0, $urandom, {$urandom, $urandom}, {$urandom, $urandom});
        run_sweep("inactive");
        check_eq("inactive_mv_chg", 64'(mv_chg - m0), 64'd0);
        check_eq("inactive_mv_pos", 64'(mv_pos_o), 64'd0);
        check_eq("inactive_busy", 64'(busy_cnt - b0), 64'(N_OBJ + 1));
        check_all("inactive_tbl");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
